s2p_framer: RTL and testbench
=============================

// Module: s2p_framer
// PURPOSE
//   Parametrised serial-to-parallel deserialiser: gathers DATA_WIDTH enabled serial bits into a word.
//   Bit order is configurable. The word is presented on a valid/ready output with a sticky overrun flag.
//   Sits between a bit-serial link front end and word-wide consumers.
//   Fixes the one-idle-cycle gap between words: frames are back-to-back, no dead enabled cycle.
// PARAMETERS
//   DATA_WIDTH   64  bits per word; legal range >= 2
//   LSB_FIRST    1   1: first bit received -> data_out[0]; 0: first bit received -> data_out[DATA_WIDTH-1]
//   COUNT_WIDTH  16  width of word_count
//   PARITY_ODD   0   parity sense, used only with S2P_PARITY_EN; 0 = even, 1 = odd
// PORTS
//   clk          in   1            rising-edge clock
//   rst          in   1            asynchronous reset, active-high
//   enable       in   1            bit strobe; serial_in is sampled on clk edges where enable=1
//   serial_in    in   1            serial data bit
//   out_ready    in   1            consumer accepts data_out when data_valid & out_ready at a clk edge
//   ovr_clr      in   1            synchronous clear of overrun
//   data_out     out  DATA_WIDTH   assembled word; stable while data_valid=1
//   data_valid   out  1            word available; held until accepted
//   overrun      out  1            sticky: a completed word was dropped
//   parity_err   out  1            parity mismatch of the presented word; qualified by data_valid
//   word_count   out  COUNT_WIDTH  words loaded into the output register, modulo 2^COUNT_WIDTH
// BEHAVIOUR
//   Reset (async, rst=1):
//     data_out=0, data_valid=0, overrun=0, parity_err=0, word_count=0.
//     Bit counter and shift register are cleared; FSM goes to DATA.
//     rst mid-word discards the partial word. A pending unaccepted word is lost without setting overrun.
//   enable=0: all collection state holds; the output handshake still operates.
//   FSM states:
//     DATA: each enabled edge stores a bit and increments bit_cnt (width $clog2(DATA_WIDTH)).
//       LSB_FIRST=1: sreg[bit_cnt] <= serial_in.
//       LSB_FIRST=0: sreg <= {sreg[DATA_WIDTH-2:0], serial_in}.
//       The enabled edge with bit_cnt==DATA_WIDTH-1 completes the frame, sets bit_cnt=0 and
//       produces a "word event" (or goes to PARITY when the macro is defined).
//     PARITY: exists only with the macro. Next enabled edge samples the parity bit,
//       produces the word event, and returns to DATA.
//   Word event, with assembled word W:
//     if !data_valid | out_ready:
//       data_out<=W, data_valid<=1, word_count++ (wraps).
//       Simultaneous accept+load is seamless: data_valid stays 1.
//     else: W is dropped, overrun<=1, data_out/word_count unchanged.
//   Latency: data_valid=1 immediately after the edge that samples the frame's final bit.
//     Next frame's first bit may arrive on the following enabled edge.
//   Accept without word event: data_valid<=0 on the edge where data_valid & out_ready.
//   data_out retains its last value when data_valid=0.
//   overrun: clears on ovr_clr=1. If ovr_clr and a drop coincide on the same edge, set wins.
//   sreg is cleared on each word event, so no stale bits carry into the next word.
// CONFIGURATION
//   S2P_PARITY_EN defined:
//     Frame = DATA_WIDTH data bits + 1 parity bit.
//     parity_err = (^W ^ pbit) != PARITY_ODD; it is loaded together with data_out.
//     A dropped word never affects parity_err.
//   S2P_PARITY_EN undefined:
//     Frame = DATA_WIDTH bits; PARITY state absent; parity_err is tied 0 (port is still present).
// TESTING (bench: DATA_WIDTH=8, COUNT_WIDTH=4, out_ready=1 unless stated)
//   1. LSB_FIRST=1, bits 1,0,1,1,0,0,1,0 on consecutive enabled edges
//      -> data_out=8'h4D, data_valid=1 right after the 8th edge, word_count=1.
//   2. LSB_FIRST=0, same bits -> data_out=8'hB2.
//      Next 8 bits back-to-back with no gap -> second word valid exactly 8 edges later.
//   3. out_ready=0, send two words -> first word held, overrun=1 after the 16th bit, word_count=1.
//      Then ovr_clr pulse -> overrun=0.
//   4. enable toggled 1/0 every cycle and rst pulsed after 5 bits
//      -> all outputs 0; next 8 enabled bits form a clean word.
//   5. 17 words streamed -> word_count wraps to 1.
//      Accept coinciding with a word event -> data_valid stays 1 with no drop.
//   6. S2P_PARITY_EN, PARITY_ODD=0: data 8'h4D (4 ones) with parity bit 0 -> parity_err=0;
//      same data with parity bit 1 -> parity_err=1.
//      Without the macro -> parity_err constantly 0.

Source files
------------

// File: rtl/s2p_framer_if.sv
// Word-side bundle of the serial-to-parallel framer: bit strobe inputs, output word handshake and status.
// master = the framer, slave = link front end plus word consumer.
interface s2p_framer_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int COUNT_WIDTH = 16
);
  logic                   enable;
  logic                   serial_in;
  logic                   out_ready;
  logic                   ovr_clr;
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   data_valid;
  logic                   overrun;
  logic                   parity_err;
  logic [COUNT_WIDTH-1:0] word_count;

  modport master (
    input  enable, serial_in, out_ready, ovr_clr,
    output data_out, data_valid, overrun, parity_err, word_count
  );

  modport slave (
    output enable, serial_in, out_ready, ovr_clr,
    input  data_out, data_valid, overrun, parity_err, word_count
  );
endinterface

// File: rtl/s2p_framer.sv
// Serial-to-parallel framer (optional parity bit via S2P_PARITY_EN); word valid right after its last bit, no inter-frame gap.
// Backpressure: a completed word meeting an unaccepted held word is dropped and sets sticky overrun.
module s2p_framer #(
  parameter int DATA_WIDTH  = 64,
  parameter bit LSB_FIRST   = 1'b1,
  parameter int COUNT_WIDTH = 16,
  parameter bit PARITY_ODD  = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  s2p_framer_if.master  bus
);
  localparam int CW = $clog2(DATA_WIDTH);

`ifdef S2P_PARITY_EN
  typedef enum logic {ST_DATA = 1'b0, ST_PARITY = 1'b1} state_e;
`else
  typedef enum logic [0:0] {ST_DATA = 1'b0} state_e;
`endif

  state_e                 state_q, state_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  sreg_q, sreg_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   vld_q, vld_d;
  logic                   ovr_q, ovr_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   word_evt;
  logic [DATA_WIDTH-1:0]  word_w;
`ifdef S2P_PARITY_EN
  logic                   perr_q, perr_d;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sreg_d    = sreg_q;
    data_d    = data_q;
    vld_d     = vld_q;
    ovr_d     = ovr_q;
    cnt_d     = cnt_q;
    word_evt  = 1'b0;
    word_w    = sreg_q;
`ifdef S2P_PARITY_EN
    perr_d    = perr_q;
`endif

    if (vld_q && bus.out_ready) vld_d = 1'b0;
    if (bus.ovr_clr) ovr_d = 1'b0;

    if (bus.enable) begin
      case (state_q)
        ST_DATA: begin
          if (LSB_FIRST) sreg_d[bit_cnt_q] = bus.serial_in;
          else           sreg_d = {sreg_q[DATA_WIDTH-2:0], bus.serial_in};
          if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
`ifdef S2P_PARITY_EN
            state_d   = ST_PARITY;
`else
            word_evt  = 1'b1;
            word_w    = sreg_d;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
`ifdef S2P_PARITY_EN
        ST_PARITY: begin
          word_evt = 1'b1;
          word_w   = sreg_q;
          state_d  = ST_DATA;
        end
`endif
        default: state_d = ST_DATA;
      endcase
    end

    // A load in the same edge as an accept keeps data_valid high (seamless hand-over).
    if (word_evt) begin
      sreg_d = '0;
      if (!vld_q || bus.out_ready) begin
        data_d = word_w;
        vld_d  = 1'b1;
        cnt_d  = cnt_q + COUNT_WIDTH'(1);
`ifdef S2P_PARITY_EN
        perr_d = ((^word_w) ^ bus.serial_in) != PARITY_ODD;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_DATA;
      bit_cnt_q <= '0;
      sreg_q    <= '0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      ovr_q     <= 1'b0;
      cnt_q     <= '0;
`ifdef S2P_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sreg_q    <= sreg_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      ovr_q     <= ovr_d;
      cnt_q     <= cnt_d;
`ifdef S2P_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = vld_q;
  assign bus.overrun    = ovr_q;
  assign bus.word_count = cnt_q;
`ifdef S2P_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = PARITY_ODD & 1'b0;
`endif
endmodule

// File: tb/tb_s2p_framer.sv
// Bench for s2p_framer: two instances (LSB-first and MSB-first) share one bit stream; a queue model predicts words.
`timescale 1ns/1ps
module tb_s2p_framer;
  localparam int DW   = 8;
  localparam int CWD  = 4;
  localparam bit PODD = 1'b0;
`ifdef S2P_PARITY_EN
  localparam int FRAME = DW + 1;
`else
  localparam int FRAME = DW;
`endif

  typedef struct {
    logic [DW-1:0] wl;
    logic [DW-1:0] wm;
    logic          pe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic sin = 1'b0;
  logic rdy = 1'b1;
  logic clr = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  s2p_framer_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CWD)) bus_l ();
  s2p_framer_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CWD)) bus_m ();

  assign bus_l.enable    = en;
  assign bus_l.serial_in = sin;
  assign bus_l.out_ready = rdy;
  assign bus_l.ovr_clr   = clr;
  assign bus_m.enable    = en;
  assign bus_m.serial_in = sin;
  assign bus_m.out_ready = rdy;
  assign bus_m.ovr_clr   = clr;

  s2p_framer #(.DATA_WIDTH(DW), .LSB_FIRST(1'b1), .COUNT_WIDTH(CWD), .PARITY_ODD(PODD)) dut_l (
    .clk(clk), .rst(rst), .bus(bus_l)
  );
  s2p_framer #(.DATA_WIDTH(DW), .LSB_FIRST(1'b0), .COUNT_WIDTH(CWD), .PARITY_ODD(PODD)) dut_m (
    .clk(clk), .rst(rst), .bus(bus_m)
  );

  // Reference model: bits of the frame in progress, plus the expected output register contents.
  logic          mq[$];
  logic          m_vld;
  logic [DW-1:0] m_dl, m_dm;
  logic [CWD-1:0] m_cnt;
  logic          m_ovr, m_perr;
  exp_t          sbq[$];
  exp_t          mon_x;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    sbq.delete();
    m_vld  = 1'b0;
    m_dl   = '0;
    m_dm   = '0;
    m_cnt  = '0;
    m_ovr  = 1'b0;
    m_perr = 1'b0;
  endtask

  task automatic check_outputs();
    chk("vld_l",  bus_l.data_valid, m_vld);
    chk("vld_m",  bus_m.data_valid, m_vld);
    chk("data_l", bus_l.data_out,   m_dl);
    chk("data_m", bus_m.data_out,   m_dm);
    chk("cnt_l",  bus_l.word_count, m_cnt);
    chk("cnt_m",  bus_m.word_count, m_cnt);
    chk("ovr_l",  bus_l.overrun,    m_ovr);
    chk("ovr_m",  bus_m.overrun,    m_ovr);
    chk("perr_l", bus_l.parity_err, m_perr);
    chk("perr_m", bus_m.parity_err, m_perr);
  endtask

  // Called at posedge+2; asserts reset between edges and releases it after the next edge.
  task automatic reset_dut();
    en = 1'b0; clr = 1'b0;
    rst = 1'b1;
    #1;
    model_clear();
    check_outputs();
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  // One clock with the given inputs; the model predicts the state right after the edge.
  task automatic step(input logic e, input logic b, input logic r, input logic c);
    logic          old, evt, pe;
    logic [DW-1:0] wl, wm;
    exp_t          x;
    en = e; sin = b; rdy = r; clr = c;
    old = m_vld; evt = 1'b0; pe = 1'b0; wl = '0; wm = '0;
    if (e) begin
      mq.push_back(b);
      if (mq.size() == FRAME) begin
        for (int i = 0; i < DW; i++) begin
          wl[i]        = mq[i];
          wm[DW-1-i]   = mq[i];
        end
`ifdef S2P_PARITY_EN
        pe = ((^wl) ^ mq[DW]) != PODD;
`endif
        mq.delete();
        evt = 1'b1;
      end
    end
    if (old && r) m_vld = 1'b0;
    if (c) m_ovr = 1'b0;
    if (evt) begin
      if (!old || r) begin
        m_vld = 1'b1; m_dl = wl; m_dm = wm; m_perr = pe; m_cnt = m_cnt + 1'b1;
        x.wl = wl; x.wm = wm; x.pe = pe;
        sbq.push_back(x);
      end else begin
        m_ovr = 1'b1;
      end
    end
    @(posedge clk); #2;
    check_outputs();
  endtask

  // Sends w LSB-first (plus parity bit pb when framed with parity); gap inserts a disabled cycle before each bit.
  task automatic send_word(input logic [DW-1:0] w, input logic pb, input logic r, input bit gap);
    logic [DW:0] fr;
    fr = {pb, w};
    for (int i = 0; i < FRAME; i++) begin
      if (gap) step(1'b0, 1'($urandom_range(0, 1)), r, 1'b0);
      step(1'b1, fr[i], r, 1'b0);
    end
  endtask

  // Scoreboard monitor: every accepted word must be the oldest predicted load.
  always @(negedge clk) begin
    if (!rst && bus_l.data_valid && bus_l.out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty got word %0h expected none at %0t", bus_l.data_out, $time);
      end else begin
        mon_x = sbq.pop_front();
        chk("sb_lsb",  bus_l.data_out,   mon_x.wl);
        chk("sb_msb",  bus_m.data_out,   mon_x.wm);
        chk("sb_perr", bus_l.parity_err, mon_x.pe);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    model_clear();
    #3;
    @(posedge clk); #2;
    reset_dut();

    // Directed 1/2: known pattern in both bit orders, then a back-to-back word.
    send_word(8'h4D, 1'b0, 1'b1, 1'b0);
    chk("t1_lsb_word", bus_l.data_out, 8'h4D);
    chk("t2_msb_word", bus_m.data_out, 8'hB2);
    chk("t1_count",    bus_l.word_count, 4'd1);
    w = 8'h3C;
    send_word(w, ^w, 1'b1, 1'b0);
    chk("t2_count2", bus_m.word_count, 4'd2);

    // Directed 3: consumer stalled, second word dropped.
    reset_dut();
    send_word(8'h81, 1'b0, 1'b0, 1'b0);
    send_word(8'h7E, 1'b0, 1'b0, 1'b0);
    chk("t3_ovr",   bus_l.overrun,    1'b1);
    chk("t3_count", bus_l.word_count, 4'd1);
    chk("t3_held",  bus_l.data_out,   8'h81);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_ovr_clr", bus_l.overrun, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Directed 4: enable toggling, reset mid-word, then a clean word.
    reset_dut();
    for (int i = 0; i < 10; i++) step(1'(i % 2 == 0), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    reset_dut();
    send_word(8'hA5, 1'b0, 1'b1, 1'b1);
    chk("t4_word", bus_l.data_out, 8'hA5);

    // Directed 5: 17 back-to-back words wrap the count, accepts coincide with loads.
    reset_dut();
    for (int k = 0; k < 17; k++) begin
      w = 8'($urandom);
      send_word(w, ^w, 1'b1, 1'b0);
    end
    chk("t5_wrap", bus_l.word_count, 4'd1);
    chk("t5_vld",  bus_l.data_valid, 1'b1);
    chk("t5_novr", bus_l.overrun,    1'b0);

`ifdef S2P_PARITY_EN
    // Directed 6: parity sense.
    reset_dut();
    send_word(8'h4D, 1'b0, 1'b1, 1'b0);
    chk("t6_par_ok",  bus_l.parity_err, 1'b0);
    send_word(8'h4D, 1'b1, 1'b1, 1'b0);
    chk("t6_par_bad", bus_l.parity_err, 1'b1);
`endif

    // Randomised traffic with stalls, overrun clears and rare resets.
    reset_dut();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) reset_dut();
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
